// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory boot loader.
package imem_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 17;
  localparam int DEPTH   = 8192;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_B0,
    S_B1,
    S_B2,
    S_DONE,
    S_ERR
  } boot_state_t;

endpackage

// File: rtl/imem_boot_ctrl_byte_timeout.sv
// Idle-cycle counter between received bytes; flags the TIMEOUT-th idle cycle.
module byte_timeout #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_byte,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_idle;

  // r_idle holds the number of idle cycles already elapsed
  assign o_expired = i_active & ~i_byte & (r_idle == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else if (!i_active || i_byte) begin
      r_idle <= '0;
    end else if (!o_expired) begin
      r_idle <= r_idle + 1'b1;
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: assembles a UART byte stream into 17-bit words, writes them to
// instruction memory from address 0, and holds the CPU in reset meanwhile.
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W  = imem_pkg::ADDR_W,
  parameter int INSTR_W = imem_pkg::INSTR_W,
  parameter int DEPTH   = imem_pkg::DEPTH,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic               rx_rdy,
  input  logic [7:0]         rx_data,
  input  logic               cpu_rd_en,
  output logic               im_rd_en,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_waddr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_rst,
  output logic               busy,
  output logic               load_done,
  output logic               load_err
);

  boot_state_t        r_state, w_next;
  logic [15:0]        r_len;
  logic [ADDR_W-1:0]  r_wcnt;
  logic [7:0]         r_b0, r_b1;
  logic               r_im_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [INSTR_W-1:0] r_wdata;
  logic               r_load_err;
  logic               w_active, w_expired, w_last, w_load_done;
  logic [15:0]        w_len;

  assign w_active = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_B0) ||
                    (r_state == S_B1) || (r_state == S_B2);
  assign w_len    = {rx_data, r_len[7:0]};
  assign w_last   = (r_wcnt + 1'b1) == ADDR_W'(r_len);

  byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_active),
    .i_byte    (rx_rdy),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next      = r_state;
    w_load_done = 1'b0;
    case (r_state)
      S_IDLE:   if (load_req) w_next = S_LEN_LO;
      S_LEN_LO: if (w_expired) w_next = S_ERR; else if (rx_rdy) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_expired) w_next = S_ERR;
        else if (rx_rdy) begin
          if (w_len == 16'd0)              w_next = S_DONE;
          else if (w_len > 16'(DEPTH))     w_next = S_ERR;
          else                             w_next = S_B0;
        end
      end
      S_B0:     if (w_expired) w_next = S_ERR; else if (rx_rdy) w_next = S_B1;
      S_B1:     if (w_expired) w_next = S_ERR; else if (rx_rdy) w_next = S_B2;
      S_B2:     if (w_expired) w_next = S_ERR; else if (rx_rdy) w_next = w_last ? S_DONE : S_B0;
      // Wait out the final write strobe so load_done never overlaps it
      S_DONE: begin
        if (!r_im_we) begin
          w_load_done = 1'b1;
          w_next      = S_IDLE;
        end
      end
      S_ERR:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_im_we    <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_im_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wcnt <= '0;
          if (load_req) r_load_err <= 1'b0;
        end
        S_LEN_LO: if (rx_rdy) r_len[7:0]  <= rx_data;
        S_LEN_HI: if (rx_rdy) r_len[15:8] <= rx_data;
        S_B0:     if (rx_rdy) r_b0 <= rx_data;
        S_B1:     if (rx_rdy) r_b1 <= rx_data;
        S_B2: begin
          if (rx_rdy) begin
            r_im_we <= 1'b1;
            r_waddr <= r_wcnt;
            r_wdata <= INSTR_W'({rx_data, r_b1, r_b0});
            r_wcnt  <= r_wcnt + 1'b1;
          end
        end
        S_ERR:    r_load_err <= 1'b1;
        default:  ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign cpu_rst   = busy;
  assign im_rd_en  = cpu_rd_en & ~busy;
  assign im_we     = r_im_we;
  assign im_waddr  = r_waddr;
  assign im_wdata  = r_wdata;
  assign load_done = w_load_done;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: stream-level reference model plus
// directed load scenarios with literal checkpoints.
module tb_imem_boot_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cpu_rd_en = 1'b0;
  logic        im_rd_en, im_we, cpu_rst, busy, load_done, load_err;
  logic [15:0] im_waddr;
  logic [16:0] im_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  imem_boot_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .cpu_rd_en(cpu_rd_en), .im_rd_en(im_rd_en), .im_we(im_we), .im_waddr(im_waddr),
    .im_wdata(im_wdata), .cpu_rst(cpu_rst), .busy(busy), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 receiving, 2 finishing, 3 error pending
  int          ph, nb, len, idle, word, done_in;
  logic [7:0]  bb [3];
  logic        e_we, e_err;
  logic [15:0] e_waddr;
  logic [16:0] e_wdata;

  task automatic model_reset();
    ph = 0; nb = 0; len = 0; idle = 0; word = 0; done_in = 0;
    e_we = 0; e_err = 0; e_waddr = 0; e_wdata = 0;
  endtask

  task automatic model_step();
    int k;
    e_we = 1'b0;
    case (ph)
      0: if (load_req) begin ph = 1; nb = 0; idle = 0; word = 0; e_err = 1'b0; end
      1: begin
        if (rx_rdy) begin
          idle = 0;
          if (nb == 0) len = int'(rx_data);
          else if (nb == 1) begin
            len = len + 256 * int'(rx_data);
            if (len == 0) begin ph = 2; done_in = 0; end
            else if (len > 8192) ph = 3;
          end else begin
            k = (nb - 2) % 3;
            bb[k] = rx_data;
            if (k == 2) begin
              e_we = 1'b1; e_waddr = 16'(word); e_wdata = {bb[2][0], bb[1], bb[0]};
              word++;
              if (word == len) begin ph = 2; done_in = 1; end
            end
          end
          nb++;
        end else begin
          idle++;
          if (idle == TMO) ph = 3;
        end
      end
      2: if (done_in > 0) done_in--; else ph = 0;
      3: begin ph = 0; e_err = 1'b1; end
      default: ph = 0;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset(); else model_step();
    end
  end

  // Observed write log and load_done pulse count, cleared by the stimulus
  logic [15:0] log_addr [$];
  logic [16:0] log_data [$];
  int          done_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        chk("busy",      {31'b0, busy},      {31'b0, ph != 0});
        chk("cpu_rst",   {31'b0, cpu_rst},   {31'b0, ph != 0});
        chk("load_done", {31'b0, load_done}, {31'b0, (ph == 2) && (done_in == 0)});
        chk("load_err",  {31'b0, load_err},  {31'b0, e_err});
        chk("im_we",     {31'b0, im_we},     {31'b0, e_we});
        chk("im_rd_en",  {31'b0, im_rd_en},  {31'b0, cpu_rd_en & (ph == 0)});
        if (e_we) begin
          chk("im_waddr", {16'b0, im_waddr}, {16'b0, e_waddr});
          chk("im_wdata", {15'b0, im_wdata}, {15'b0, e_wdata});
        end
        if (im_we) begin log_addr.push_back(im_waddr); log_data.push_back(im_wdata); end
        if (load_done) done_cnt++;
      end
    end
  end

  task automatic tick(); @(negedge clk); #2; endtask
  task automatic ticks(input int n); for (int i = 0; i < n; i++) tick(); endtask
  task automatic send_byte(input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b; tick(); rx_rdy = 1'b0;
  endtask
  task automatic start_load();
    load_req = 1'b1; tick(); load_req = 1'b0;
  endtask
  task automatic clear_log();
    log_addr.delete(); log_data.delete(); done_cnt = 0;
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_we"},    {31'b0, im_we},     0);
    chk({tag, "_busy"},  {31'b0, busy},      0);
    chk({tag, "_cpurst"},{31'b0, cpu_rst},   0);
    chk({tag, "_done"},  {31'b0, load_done}, 0);
    chk({tag, "_err"},   {31'b0, load_err},  0);
    chk({tag, "_waddr"}, {16'b0, im_waddr},  0);
    chk({tag, "_wdata"}, {15'b0, im_wdata},  0);
  endtask

  logic [7:0] n3_bytes [11] = '{8'h03, 8'h00, 8'hCD, 8'hAB, 8'hFF, 8'h01, 8'h00, 8'h00,
                                8'hFF, 8'hFF, 8'h03};

  initial begin
    ticks(2);
    #1;
    chk_reset_outs("rst");
    rst = 1'b0;
    ticks(2);

    // N=3 back-to-back, fetch requested throughout, extra load_req mid-load
    clear_log();
    cpu_rd_en = 1'b1;
    start_load();
    chk("n3_busy_rise", {31'b0, busy}, 1);
    chk("n3_rd_blocked", {31'b0, im_rd_en}, 0);
    for (int i = 0; i < 11; i++) begin
      if (i == 5) load_req = 1'b1;
      send_byte(n3_bytes[i]);
      load_req = 1'b0;
    end
    chk("n3_last_we", {31'b0, im_we}, 1);
    chk("n3_done_not_yet", {31'b0, load_done}, 0);
    tick();
    chk("n3_done_pulse", {31'b0, load_done}, 1);
    chk("n3_busy_during_done", {31'b0, busy}, 1);
    tick();
    chk("n3_busy_fall", {31'b0, busy}, 0);
    chk("n3_rd_pass", {31'b0, im_rd_en}, 1);
    ticks(3);
    chk("n3_nwrites", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("n3_a0", {16'b0, log_addr[0]}, 0); chk("n3_d0", {15'b0, log_data[0]}, 32'h1ABCD);
      chk("n3_a1", {16'b0, log_addr[1]}, 1); chk("n3_d1", {15'b0, log_data[1]}, 32'h00001);
      chk("n3_a2", {16'b0, log_addr[2]}, 2); chk("n3_d2", {15'b0, log_data[2]}, 32'h1FFFF);
    end
    chk("n3_done_cnt", done_cnt, 1);
    cpu_rd_en = 1'b0;

    // Stray byte while idle, then N=0
    send_byte(8'h55);
    clear_log();
    start_load();
    send_byte(8'h00);
    send_byte(8'h00);
    chk("n0_done_imm", {31'b0, load_done}, 1);
    tick();
    chk("n0_busy_fall", {31'b0, busy}, 0);
    ticks(2);
    chk("n0_nwrites", log_addr.size(), 0);
    chk("n0_done_cnt", done_cnt, 1);

    // Length 8193 rejected; next load_req clears the error flag
    clear_log();
    start_load();
    send_byte(8'h01);
    send_byte(8'h20);
    ticks(2);
    chk("len_err_flag", {31'b0, load_err}, 1);
    chk("len_err_busy", {31'b0, busy}, 0);
    chk("len_err_nwrites", log_addr.size(), 0);
    start_load();
    chk("len_err_cleared", {31'b0, load_err}, 0);
    send_byte(8'h00);
    send_byte(8'h00);
    ticks(3);

    // Stall after 2 bytes of word 1
    clear_log();
    start_load();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55);
    ticks(TMO - 1);
    chk("tmo_still_busy", {31'b0, busy}, 1);
    ticks(3);
    chk("tmo_err", {31'b0, load_err}, 1);
    chk("tmo_cpu_rst", {31'b0, cpu_rst}, 0);
    chk("tmo_nwrites", log_addr.size(), 1);
    if (log_addr.size() == 1) chk("tmo_d0", {15'b0, log_data[0]}, 32'h12211);

    // Full-depth length accepted, reset asserted in B1
    clear_log();
    start_load();
    send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h77);
    chk("depth_ok_busy", {31'b0, busy}, 1);
    chk("depth_ok_noerr", {31'b0, load_err}, 0);
    rst = 1'b1;
    #1;
    chk_reset_outs("midrst");
    ticks(2);
    rst = 1'b0;
    tick();

    // Fresh load after reset starts at address 0
    clear_log();
    start_load();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h45); send_byte(8'h23); send_byte(8'h01);
    ticks(4);
    chk("post_rst_nwrites", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      chk("post_rst_a0", {16'b0, log_addr[0]}, 0);
      chk("post_rst_d0", {15'b0, log_data[0]}, 32'h12345);
    end
    chk("post_rst_done_cnt", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
